// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the core front end.
// Holds the fetch PC, advances it by the decoded instruction length, and
// applies branches, jumps and call/return through a small return-address
// stack. Stack misuse and illegal length classes park the block in FAULT
// until fault_clear.
module pc_sequencer #(
   parameter int WORD_WIDTH         = 32,
   parameter int PROGRAM_ADDR_WIDTH = 16,
   parameter int CALL_DEPTH         = 8,
   parameter logic [PROGRAM_ADDR_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                start,
   input  logic                                inst_valid,
   input  logic                                stall,
   input  logic [2:0]                          len_class,
   input  logic                                branch_taken,
   input  logic [15:0]                         branch_offset,
   input  logic                                jump,
   input  logic                                call,
   input  logic                                ret,
   input  logic [PROGRAM_ADDR_WIDTH-1:0]       jump_target,
   input  logic                                fault_clear,
   output logic [PROGRAM_ADDR_WIDTH-1:0]       pc,
   output logic                                running,
   output logic [$clog2(CALL_DEPTH+1)-1:0]     stack_depth,
   output logic                                fault,
   output logic [1:0]                          fault_code
);

   localparam int AW       = PROGRAM_ADDR_WIDTH;
   localparam int DW       = $clog2(CALL_DEPTH + 1);
   localparam int IW       = $clog2(CALL_DEPTH);
   localparam int OW       = (AW > 16) ? AW : 16;
   localparam int WORD_LEN = 1 + WORD_WIDTH / 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FAULT
   } state_e;

   typedef enum logic [1:0] {
      FC_NONE      = 2'd0,
      FC_OVERFLOW  = 2'd1,
      FC_UNDERFLOW = 2'd2,
      FC_LEN       = 2'd3
   } fault_e;

   state_e          state_q, state_d;
   fault_e          code_q,  code_d;
   logic [AW-1:0]   pc_q,    pc_d;
   logic [DW-1:0]   depth_q, depth_d;
   logic            push_en;

   logic [AW-1:0]   stack_q [CALL_DEPTH];
   logic [IW-1:0]   push_idx;
   logic [IW-1:0]   pop_idx;

   logic [AW-1:0]   inst_len;
   logic [AW-1:0]   seq_pc;
   logic [OW-1:0]   off_ext;
   logic [AW-1:0]   br_target;

   // Slot indices: the next free entry is at depth, the top entry one below.
   // A full stack of a power-of-two depth wraps push_idx to 0 and pop_idx to
   // the last entry, which is exactly the top.
   assign push_idx = depth_q[IW-1:0];
   assign pop_idx  = push_idx - IW'(1);

   // Decode the instruction length; illegal classes never advance the PC.
   always_comb begin
      inst_len = '0;
      case (len_class)
         3'd0:    inst_len = AW'(1);
         3'd1:    inst_len = AW'(2);
         3'd2:    inst_len = AW'(3);
         3'd3:    inst_len = AW'(5);
         3'd4:    inst_len = AW'(WORD_LEN);
         3'd5:    inst_len = AW'(9);
         default: inst_len = '0;
      endcase
   end

   // Fall-through and branch targets, both wrapping modulo 2^AW.
   assign seq_pc    = pc_q + inst_len;
   assign off_ext   = OW'($signed(branch_offset));
   assign br_target = pc_q + off_ext[AW-1:0];

   // Next-state and next-PC selection with retire priority.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no path can
      // leave it unassigned, which would otherwise infer a latch.
      state_d = state_q;
      code_d  = code_q;
      pc_d    = pc_q;
      depth_d = depth_q;
      push_en = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_RUN;
         end

         S_RUN: begin
            if (inst_valid && !stall) begin
               if (len_class > 3'd5) begin
                  state_d = S_FAULT;
                  code_d  = FC_LEN;
               end else if (ret) begin
                  if (depth_q == '0) begin
                     state_d = S_FAULT;
                     code_d  = FC_UNDERFLOW;
                  end else begin
                     pc_d    = stack_q[pop_idx];
                     depth_d = depth_q - DW'(1);
                  end
               end else if (call) begin
                  if (depth_q == DW'(CALL_DEPTH)) begin
                     state_d = S_FAULT;
                     code_d  = FC_OVERFLOW;
                  end else begin
                     push_en = 1'b1;
                     pc_d    = jump_target;
                     depth_d = depth_q + DW'(1);
                  end
               end else if (jump) begin
                  pc_d = jump_target;
               end else if (branch_taken) begin
                  pc_d = br_target;
               end else begin
                  pc_d = seq_pc;
               end
            end
         end

         S_FAULT: begin
            if (fault_clear) begin
               state_d = S_IDLE;
               code_d  = FC_NONE;
               pc_d    = RESET_PC;
               depth_d = '0;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, PC, depth and fault-code registers.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (reset) begin
         state_q <= S_IDLE;
         code_q  <= FC_NONE;
         pc_q    <= RESET_PC;
         depth_q <= '0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         pc_q    <= pc_d;
         depth_q <= depth_d;
      end
   end

   // Return-address storage, written on a successful call.
   always_ff @(posedge clk) begin
      // NOTE: the entries are deliberately not reset; depth_q alone says
      // which ones are valid, so stale contents are never read.
      if (push_en) stack_q[push_idx] <= seq_pc;
   end

   assign pc          = pc_q;
   assign running     = (state_q == S_RUN);
   assign fault       = (state_q == S_FAULT);
   assign stack_depth = depth_q;
   assign fault_code  = code_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default parameters:
// WORD_WIDTH=32, 16-bit PC, 8-entry return stack, RESET_PC=0).
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        inst_valid = 1'b0;
   logic        stall = 1'b0;
   logic [2:0]  len_class = 3'd0;
   logic        branch_taken = 1'b0;
   logic [15:0] branch_offset = 16'h0;
   logic        jump = 1'b0;
   logic        call = 1'b0;
   logic        ret = 1'b0;
   logic [15:0] jump_target = 16'h0;
   logic        fault_clear = 1'b0;
   logic [15:0] pc;
   logic        running;
   logic [3:0]  stack_depth;
   logic        fault;
   logic [1:0]  fault_code;

   int vectors     = 0;
   int miscompares = 0;

   pc_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .inst_valid    (inst_valid),
      .stall         (stall),
      .len_class     (len_class),
      .branch_taken  (branch_taken),
      .branch_offset (branch_offset),
      .jump          (jump),
      .call          (call),
      .ret           (ret),
      .jump_target   (jump_target),
      .fault_clear   (fault_clear),
      .pc            (pc),
      .running       (running),
      .stack_depth   (stack_depth),
      .fault         (fault),
      .fault_code    (fault_code)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_st(input string tag, input logic [15:0] epc, input int edepth,
                            input logic erun, input logic eflt, input logic [1:0] ecode);
      check({tag, "_pc"},    32'(pc),          32'(epc));
      check({tag, "_depth"}, 32'(stack_depth), 32'(edepth));
      check({tag, "_run"},   32'(running),     32'(erun));
      check({tag, "_fault"}, 32'(fault),       32'(eflt));
      check({tag, "_code"},  32'(fault_code),  32'(ecode));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      start = 1'b0; inst_valid = 1'b0; stall = 1'b0; len_class = 3'd0;
      branch_taken = 1'b0; branch_offset = 16'h0; jump = 1'b0; call = 1'b0;
      ret = 1'b0; jump_target = 16'h0; fault_clear = 1'b0;
   endtask

   task automatic retire(input logic [2:0] lc);
      inst_valid = 1'b1;
      len_class  = lc;
      tick();
      clear_inputs();
   endtask

   task automatic do_jump(input logic [15:0] t);
      jump = 1'b1; jump_target = t;
      retire(3'd0);
   endtask

   task automatic do_call(input logic [15:0] t, input logic [2:0] lc);
      call = 1'b1; jump_target = t;
      retire(lc);
   endtask

   task automatic do_ret();
      ret = 1'b1;
      retire(3'd0);
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); clear_inputs();
   endtask

   task automatic pulse_clear();
      fault_clear = 1'b1; tick(); clear_inputs();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Asynchronous reset takes effect before any clock edge.
      #2 reset = 1'b1;
      #1 expect_st("reset", 16'h0000, 0, 1'b0, 1'b0, 2'd0);
      tick();
      reset = 1'b0;
      tick();

      // IDLE ignores instructions and control.
      inst_valid = 1'b1; len_class = 3'd1; jump = 1'b1; jump_target = 16'h0055;
      tick(); clear_inputs();
      expect_st("idle_hold", 16'h0000, 0, 1'b0, 1'b0, 2'd0);

      pulse_start();
      expect_st("start", 16'h0000, 0, 1'b1, 1'b0, 2'd0);

      // Sequential advance over every legal length class.
      retire(3'd0); check("len0", 32'(pc), 32'd1);
      retire(3'd1); check("len1", 32'(pc), 32'd3);
      retire(3'd2); check("len2", 32'(pc), 32'd6);
      retire(3'd3); check("len3", 32'(pc), 32'd11);
      retire(3'd4); check("len4", 32'(pc), 32'd16);
      retire(3'd5); check("len5", 32'(pc), 32'd25);

      // Stall with call: nothing retires.
      stall = 1'b1; call = 1'b1; jump_target = 16'h0100;
      retire(3'd0);
      expect_st("stall_call", 16'd25, 0, 1'b1, 1'b0, 2'd0);

      // No valid instruction: jump ignored; fault_clear in RUN has no effect.
      jump = 1'b1; jump_target = 16'h0100; fault_clear = 1'b1;
      tick(); clear_inputs();
      expect_st("novalid", 16'd25, 0, 1'b1, 1'b0, 2'd0);

      // Jumps and relative branches.
      do_jump(16'h0010); check("jump", 32'(pc), 32'h0010);
      branch_taken = 1'b1; branch_offset = 16'hFFFC;
      retire(3'd0); check("branch_neg", 32'(pc), 32'h000C);
      jump = 1'b1; jump_target = 16'h0040; branch_taken = 1'b1; branch_offset = 16'h0004;
      retire(3'd0); check("jump_over_branch", 32'(pc), 32'h0040);
      branch_taken = 1'b1; branch_offset = 16'h0010;
      retire(3'd2); check("branch_pos", 32'(pc), 32'h0050);

      // Wrap-around of sequential and branch targets.
      do_jump(16'hFFFE);
      retire(3'd3); check("seq_wrap", 32'(pc), 32'h0003);
      do_jump(16'h0002);
      branch_taken = 1'b1; branch_offset = 16'hFFFC;
      retire(3'd0); check("branch_wrap", 32'(pc), 32'hFFFE);

      // Call and return, ret taking priority over call and jump.
      do_jump(16'h0020);
      do_call(16'h0100, 3'd0);
      expect_st("call", 16'h0100, 1, 1'b1, 1'b0, 2'd0);
      retire(3'd1); check("in_callee", 32'(pc), 32'h0102);
      ret = 1'b1; call = 1'b1; jump = 1'b1; jump_target = 16'h0777;
      retire(3'd0);
      expect_st("ret", 16'h0021, 0, 1'b1, 1'b0, 2'd0);

      // Underflow fault; FAULT freezes pc against control and start.
      do_ret();
      expect_st("underflow", 16'h0021, 0, 1'b0, 1'b1, 2'd2);
      jump = 1'b1; jump_target = 16'h0077; start = 1'b1;
      retire(3'd0);
      expect_st("fault_frozen", 16'h0021, 0, 1'b0, 1'b1, 2'd2);
      pulse_clear();
      expect_st("clear1", 16'h0000, 0, 1'b0, 1'b0, 2'd0);

      // Illegal length classes beat every other control input.
      pulse_start();
      ret = 1'b1; jump = 1'b1; jump_target = 16'h0123;
      retire(3'd7);
      expect_st("len7", 16'h0000, 0, 1'b0, 1'b1, 2'd3);
      pulse_clear();
      pulse_start();
      retire(3'd6);
      expect_st("len6", 16'h0000, 0, 1'b0, 1'b1, 2'd3);
      pulse_clear();

      // Fill the return stack, unwind part of it, refill, then overflow.
      pulse_start();
      for (int i = 0; i < 8; i++) begin
         do_call(16'h1000 + 16'(i * 16), 3'd0);
         check("nest_pc", 32'(pc), 32'h1000 + 32'(i * 16));
         check("nest_depth", 32'(stack_depth), 32'(i + 1));
      end
      do_ret();
      expect_st("unwind1", 16'h1061, 7, 1'b1, 1'b0, 2'd0);
      do_ret();
      expect_st("unwind2", 16'h1051, 6, 1'b1, 1'b0, 2'd0);
      do_call(16'h2000, 3'd1);
      expect_st("refill1", 16'h2000, 7, 1'b1, 1'b0, 2'd0);
      do_call(16'h3000, 3'd2);
      expect_st("refill2", 16'h3000, 8, 1'b1, 1'b0, 2'd0);
      do_ret();
      expect_st("full_ret", 16'h2003, 7, 1'b1, 1'b0, 2'd0);
      do_ret();
      expect_st("deep_ret", 16'h1053, 6, 1'b1, 1'b0, 2'd0);
      do_call(16'h3000, 3'd0);
      do_call(16'h3100, 3'd0);
      expect_st("full_again", 16'h3100, 8, 1'b1, 1'b0, 2'd0);
      do_call(16'h4000, 3'd0);
      expect_st("overflow", 16'h3100, 8, 1'b0, 1'b1, 2'd1);
      pulse_clear();
      expect_st("clear2", 16'h0000, 0, 1'b0, 1'b0, 2'd0);

      // A return address that wrapped is stored wrapped.
      pulse_start();
      do_jump(16'hFFFF);
      do_call(16'h0300, 3'd5);
      expect_st("wrap_call", 16'h0300, 1, 1'b1, 1'b0, 2'd0);
      do_ret();
      expect_st("wrap_ret", 16'h0008, 0, 1'b1, 1'b0, 2'd0);

      // Reset mid-operation acts before the next clock edge.
      do_call(16'h0300, 3'd0);
      do_call(16'h0400, 3'd0);
      do_call(16'h0200, 3'd0);
      expect_st("pre_reset", 16'h0200, 3, 1'b1, 1'b0, 2'd0);
      #3 reset = 1'b1;
      #1 expect_st("async_reset", 16'h0000, 0, 1'b0, 1'b0, 2'd0);
      tick();
      reset = 1'b0;
      tick();
      expect_st("post_reset", 16'h0000, 0, 1'b0, 1'b0, 2'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
